ssm_y_stream_out: RTL and testbench

// - Downstream of the tiled SSM packing stage; consumes its full y frame (B*H*P fp16 words) on its done pulse.
// - Ping-pong buffers two frames so the next SSM step can run while the previous y streams out.
// - Streams y as valid/ready beats of LANES words each, word 0 first, toward the output projection.
// - No arithmetic: a pure buffering and serialising stage.

---
 rtl/ssm_pkg.sv | 14 +
 rtl/ssm_y_stream_out.sv | 134 +++++++++++++
 tb/tb_ssm_y_stream_out.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ssm_pkg.sv
// Shared SSM datapath package.
// Holds the fp16 word width and type, plus the default B/H/P/N geometry shared
// by the packing, tile and output-stream blocks.
package ssm_pkg;

    localparam int unsigned DEF_DW = 16;   // fp16 word width
    localparam int unsigned DEF_B  = 1;    // batch size
    localparam int unsigned DEF_H  = 24;   // heads
    localparam int unsigned DEF_P  = 64;   // head dimension
    localparam int unsigned DEF_N  = 16;   // state dimension

    typedef logic [DEF_DW-1:0] fp16_t;

endpackage

// File: rtl/ssm_y_stream_out.sv
// Ping-pong buffer and serialiser for the SSM y frame.
// Captures a whole B*H*P-word y frame on y_done into one of two banks, then
// streams it out as valid/ready beats of LANES words, word 0 first, while the
// other bank is free to accept the next frame.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   y_flat_in     full y frame, word k at [DW*k +: DW]
//   y_done        1-cycle pulse, y_flat_in valid this cycle
//   in_ready      a bank is free (depends on fill count only)
//   m_valid       output beat valid
//   m_ready       downstream accepts the beat
//   m_data        LANES words of the current beat, lowest word in LSBs
//   m_last        final beat of a frame
//   m_frame_id    id of the frame being streamed, wraps
//   overflow      sticky: a y_done arrived with both banks full and was dropped
module ssm_y_stream_out
    import ssm_pkg::*;
#(
    parameter int unsigned B     = DEF_B,
    parameter int unsigned H     = DEF_H,
    parameter int unsigned P     = DEF_P,
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned LANES = 16,
    parameter int unsigned FIDW  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [B*H*P*DW-1:0]    y_flat_in,
    input  logic                   y_done,
    output logic                   in_ready,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [LANES*DW-1:0]    m_data,
    output logic                   m_last,
    output logic [FIDW-1:0]        m_frame_id,
    output logic                   overflow
);

    localparam int unsigned WORDS  = B * H * P;
    localparam int unsigned NBEATS = WORDS / LANES;
    localparam int unsigned BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned BEATW  = LANES * DW;

    if (WORDS % LANES != 0) begin : g_bad_lanes
        $error("ssm_y_stream_out: B*H*P must be a multiple of LANES");
    end

    logic [WORDS*DW-1:0] bank0_q, bank1_q;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [1:0]          full_cnt_q, full_cnt_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [FIDW-1:0]     fid_q, fid_d;
    logic                overflow_q, overflow_d;

    logic                fire, last_beat, last_fire, capture, drop;
    logic [WORDS*DW-1:0] rd_frame;

    assign m_valid   = (full_cnt_q != 2'd0);
    assign in_ready  = (full_cnt_q != 2'd2);
    assign fire      = m_valid & m_ready;
    assign last_beat = (beat_q == BW'(NBEATS - 1));
    assign last_fire = fire & last_beat;
    // A frame finishing this cycle frees its bank in time for a same-cycle capture.
    assign capture   = y_done & ((full_cnt_q != 2'd2) | last_fire);
    assign drop      = y_done & ~capture;

    assign rd_frame   = rd_bank_q ? bank1_q : bank0_q;
    assign m_data     = m_valid ? rd_frame[32'(beat_q) * BEATW +: BEATW] : '0;
    assign m_last     = m_valid & last_beat;
    assign m_frame_id = fid_q;
    assign overflow   = overflow_q;

    always_comb begin
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        full_cnt_d = full_cnt_q;
        beat_d     = beat_q;
        fid_d      = fid_q;
        overflow_d = overflow_q;

        if (capture) begin
            wr_bank_d = ~wr_bank_q;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end

        if (capture && !last_fire) begin
            full_cnt_d = full_cnt_q + 2'd1;
        end else if (last_fire && !capture) begin
            full_cnt_d = full_cnt_q - 2'd1;
        end

        if (last_fire) begin
            beat_d    = '0;
            rd_bank_d = ~rd_bank_q;
            fid_d     = fid_q + FIDW'(1);
        end else if (fire) begin
            beat_d = beat_q + BW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_cnt_q <= 2'd0;
            beat_q     <= '0;
            fid_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_cnt_q <= full_cnt_d;
            beat_q     <= beat_d;
            fid_q      <= fid_d;
            overflow_q <= overflow_d;
        end
    end

    // Bank storage is not reset; contents are only meaningful once captured.
    always_ff @(posedge clk) begin
        if (capture && !rst) begin
            if (wr_bank_q) begin
                bank1_q <= y_flat_in;
            end else begin
                bank0_q <= y_flat_in;
            end
        end
    end

endmodule

// File: tb/tb_ssm_y_stream_out.sv
module tb_ssm_y_stream_out;

    localparam int unsigned B = 1, H = 2, P = 4, DW = 16, LANES = 4, FIDW = 8;
    localparam int unsigned WORDS = B * H * P;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [WORDS*DW-1:0]   y_flat_in;
    logic                  y_done;
    logic                  in_ready;
    logic                  m_valid;
    logic                  m_ready;
    logic [LANES*DW-1:0]   m_data;
    logic                  m_last;
    logic [FIDW-1:0]       m_frame_id;
    logic                  overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ssm_y_stream_out #(
        .B(B), .H(H), .P(P), .DW(DW), .LANES(LANES), .FIDW(FIDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .y_flat_in  (y_flat_in),
        .y_done     (y_done),
        .in_ready   (in_ready),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_frame_id (m_frame_id),
        .overflow   (overflow)
    );

    typedef struct {
        logic          y_done;
        logic [15:0]   base;
        logic          m_ready;
        logic          valid;
        logic [63:0]   data;
        logic          last;
        logic [7:0]    fid;
        logic          in_ready;
        logic          ovf;
    } vec_t;

    vec_t vecs[16];
    int   nvec = 0;

    function automatic logic [127:0] mkframe(input logic [15:0] base);
        logic [127:0] f;
        for (int k = 0; k < 8; k++) f[16*k +: 16] = base + 16'(k);
        return f;
    endfunction

    function automatic logic [63:0] mkbeat(input logic [15:0] base, input int b);
        logic [63:0] d;
        for (int k = 0; k < 4; k++) d[16*k +: 16] = base + 16'(4 * b + k);
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic v, input logic [63:0] d,
                           input logic l, input logic [7:0] fid, input logic ir,
                           input logic ovf);
        chk({name, ".m_valid"}, 64'(m_valid), 64'(v));
        chk({name, ".m_data"}, m_data, d);
        chk({name, ".m_last"}, 64'(m_last), 64'(l));
        chk({name, ".m_frame_id"}, 64'(m_frame_id), 64'(fid));
        chk({name, ".in_ready"}, 64'(in_ready), 64'(ir));
        chk({name, ".overflow"}, 64'(overflow), 64'(ovf));
    endtask

    task automatic add(input logic yd, input logic [15:0] base, input logic rdy,
                       input logic v, input logic [63:0] d, input logic l,
                       input logic [7:0] fid, input logic ir, input logic ovf);
        vecs[nvec] = '{yd, base, rdy, v, d, l, fid, ir, ovf};
        nvec++;
    endtask

    // Drive inputs for the next edge, then sample after it settles.
    task automatic cyc(input logic yd, input logic [15:0] base, input logic rdy);
        y_done    = yd;
        y_flat_in = mkframe(base);
        m_ready   = rdy;
        @(posedge clk);
        #1;
        y_done = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        y_done    = 1'b0;
        y_flat_in = '0;
        m_ready   = 1'b0;
        #12;
        chk_out("reset", 0, 64'h0, 0, 8'd0, 1, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single frame, then a 5-cycle stall on beat 0.
        add(1, 16'h0000, 1, 1, 64'h0003_0002_0001_0000, 0, 8'd0, 1, 0);
        add(0, 16'h0000, 1, 1, 64'h0007_0006_0005_0004, 1, 8'd0, 1, 0);
        add(0, 16'h0000, 1, 0, 64'h0,                   0, 8'd1, 1, 0);
        add(1, 16'h0100, 0, 1, mkbeat(16'h0100, 0),     0, 8'd1, 1, 0);
        for (int i = 0; i < 5; i++)
            add(0, 16'h0000, 0, 1, mkbeat(16'h0100, 0), 0, 8'd1, 1, 0);
        add(0, 16'h0000, 1, 1, mkbeat(16'h0100, 1),     1, 8'd1, 1, 0);
        add(0, 16'h0000, 1, 0, 64'h0,                   0, 8'd2, 1, 0);

        for (int i = 0; i < nvec; i++) begin
            cyc(vecs[i].y_done, vecs[i].base, vecs[i].m_ready);
            chk_out($sformatf("vec%0d", i), vecs[i].valid, vecs[i].data, vecs[i].last,
                    vecs[i].fid, vecs[i].in_ready, vecs[i].ovf);
        end

        // Back-to-back frames A, B with no bubble.
        cyc(1, 16'h1000, 0);
        chk_out("bb_capA", 1, mkbeat(16'h1000, 0), 0, 8'd2, 1, 0);
        cyc(1, 16'h2000, 0);
        chk_out("bb_capB", 1, mkbeat(16'h1000, 0), 0, 8'd2, 0, 0);
        cyc(0, 16'h0, 1);
        chk_out("bb_A1", 1, mkbeat(16'h1000, 1), 1, 8'd2, 0, 0);
        cyc(0, 16'h0, 1);
        chk_out("bb_B0", 1, mkbeat(16'h2000, 0), 0, 8'd3, 1, 0);
        cyc(0, 16'h0, 1);
        chk_out("bb_B1", 1, mkbeat(16'h2000, 1), 1, 8'd3, 1, 0);
        cyc(0, 16'h0, 1);
        chk_out("bb_end", 0, 64'h0, 0, 8'd4, 1, 0);

        // Overflow: C arrives with both banks full and no last beat leaving.
        cyc(1, 16'h1000, 0);
        cyc(1, 16'h2000, 0);
        cyc(1, 16'h3000, 0);
        chk_out("ov_drop", 1, mkbeat(16'h1000, 0), 0, 8'd4, 0, 1);
        cyc(0, 16'h0, 1);
        chk_out("ov_A1", 1, mkbeat(16'h1000, 1), 1, 8'd4, 0, 1);
        cyc(0, 16'h0, 1);
        chk_out("ov_B0", 1, mkbeat(16'h2000, 0), 0, 8'd5, 1, 1);
        cyc(0, 16'h0, 1);
        chk_out("ov_B1", 1, mkbeat(16'h2000, 1), 1, 8'd5, 1, 1);
        cyc(0, 16'h0, 1);
        chk_out("ov_end", 0, 64'h0, 0, 8'd6, 1, 1);

        rst = 1'b1;
        #2;
        chk_out("ov_rst", 0, 64'h0, 0, 8'd0, 1, 0);
        rst = 1'b0;

        // Capture coincident with the last beat of A while both banks are full.
        cyc(1, 16'h1000, 0);
        cyc(1, 16'h2000, 0);
        cyc(0, 16'h0, 1);
        chk_out("co_A1", 1, mkbeat(16'h1000, 1), 1, 8'd0, 0, 0);
        cyc(1, 16'h3000, 1);
        chk_out("co_B0", 1, mkbeat(16'h2000, 0), 0, 8'd1, 0, 0);
        cyc(0, 16'h0, 1);
        chk_out("co_B1", 1, mkbeat(16'h2000, 1), 1, 8'd1, 0, 0);
        cyc(0, 16'h0, 1);
        chk_out("co_C0", 1, mkbeat(16'h3000, 0), 0, 8'd2, 1, 0);
        cyc(0, 16'h0, 1);
        chk_out("co_C1", 1, mkbeat(16'h3000, 1), 1, 8'd2, 1, 0);
        cyc(0, 16'h0, 1);
        chk_out("co_end", 0, 64'h0, 0, 8'd3, 1, 0);

        // Asynchronous reset mid-stream with B buffered.
        cyc(1, 16'h1000, 0);
        cyc(1, 16'h2000, 0);
        cyc(0, 16'h0, 1);
        chk_out("ar_A1", 1, mkbeat(16'h1000, 1), 1, 8'd3, 0, 0);
        m_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_out("ar_rst", 0, 64'h0, 0, 8'd0, 1, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 16'h4000, 1);
        chk_out("ar_E0", 1, mkbeat(16'h4000, 0), 0, 8'd0, 1, 0);
        cyc(0, 16'h0, 1);
        chk_out("ar_E1", 1, mkbeat(16'h4000, 1), 1, 8'd0, 1, 0);
        cyc(0, 16'h0, 1);
        chk_out("ar_end", 0, 64'h0, 0, 8'd1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
